// File: rtl/ipsl_pcie_dma_pkg.sv
// Shared constants for the PCIe DMA TLP schedulers: FSM state encoding,
// max-payload decode in DW and the 4 KB host-address boundary.
package ipsl_pcie_dma_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CALC = 3'd1;
  localparam logic [2:0] ST_REQ  = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [7:0] MPS_128B_DW = 8'd32;
  localparam logic [7:0] MPS_256B_DW = 8'd64;
  localparam logic [7:0] MPS_512B_DW = 8'd128;

  // 4 KB boundary expressed in DW; a DW-aligned offset leaves 1..1024 DW.
  localparam logic [10:0] BND_4K_DW = 11'd1024;

  // Reserved MPS encodings fall back to 512 B, the largest supported size.
  function automatic logic [7:0] mps_to_dw(input logic [2:0] mps);
    case (mps)
      3'd0:    mps_to_dw = MPS_128B_DW;
      3'd1:    mps_to_dw = MPS_256B_DW;
      default: mps_to_dw = MPS_512B_DW;
    endcase
  endfunction

endpackage

// File: rtl/ipsl_pcie_dma_tlp_len_calc.sv
// Combinational TLP length: min(remaining DW, max payload DW, DW left before
// the next 4 KB host boundary). Shared by the MWR and MRD schedulers.
module ipsl_pcie_dma_tlp_len_calc
  import ipsl_pcie_dma_pkg::*;
(
  input  logic [16:0] remain_i,
  input  logic [2:0]  mps_i,
  input  logic [9:0]  addr_dw_i,
  output logic [9:0]  len_o
);

  logic [7:0]  mps_dw;
  logic [10:0] bnd_dw;
  logic [7:0]  len_rm;

  always_comb begin
    mps_dw = mps_to_dw(mps_i);
    bnd_dw = BND_4K_DW - {1'b0, addr_dw_i};
    len_rm = (remain_i > {9'd0, mps_dw}) ? mps_dw : remain_i[7:0];
    if (bnd_dw < {3'd0, len_rm}) begin
      len_o = {2'd0, bnd_dw[7:0]};
    end else begin
      len_o = {2'd0, len_rm};
    end
  end

endmodule

// File: rtl/ipsl_pcie_dma_mwr_tlp_sched.sv
// Splits one host-bound DMA write into MWR TLPs and hands each to the read
// controller. Optional counters enabled by IPSL_PCIE_DMA_MWR_PERF_CNT_EN.
module ipsl_pcie_dma_mwr_tlp_sched
  import ipsl_pcie_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_dma_start,
  input  logic [15:0]           i_dma_len,
  input  logic [63:0]           i_dma_addr,
  input  logic [2:0]            i_max_payload,
  input  logic                  i_last_data,
  output logic                  o_rd_en,
  output logic [9:0]            o_rd_length,
  output logic                  o_mwr_tx_busy,
  output logic [63:0]           o_tlp_addr,
  output logic [ADDR_WIDTH-1:0] o_ram_base,
  output logic                  o_dma_done,
`ifdef IPSL_PCIE_DMA_MWR_PERF_CNT_EN
  output logic                  o_busy,
  output logic [15:0]           o_tlp_cnt,
  output logic [31:0]           o_stall_cnt
`else
  output logic                  o_busy
`endif
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  logic [2:0]            state_q,    state_d;
  logic [16:0]           remain_q,   remain_d;
  logic [63:0]           addr_q,     addr_d;
  logic [ADDR_WIDTH-1:0] ram_base_q, ram_base_d;
  logic [9:0]            rd_len_q,   rd_len_d;
  logic [63:0]           tlp_addr_q, tlp_addr_d;
  logic                  rd_en_q,    rd_en_d;
  logic                  tx_busy_q,  tx_busy_d;
  logic                  done_q,     done_d;
  logic [7:0]            gap_q,      gap_d;

  logic [9:0]  calc_len;
  logic [8:0]  beats;
  logic [16:0] remain_nx;

  ipsl_pcie_dma_tlp_len_calc u_len_calc (
    .remain_i  (remain_q),
    .mps_i     (i_max_payload),
    .addr_dw_i (addr_q[11:2]),
    .len_o     (calc_len)
  );

  // 128-bit RAM words consumed by the current TLP: ceil(len/4).
  assign beats     = {1'b0, rd_len_q[9:2]} + {8'd0, |rd_len_q[1:0]};
  assign remain_nx = remain_q - {7'd0, rd_len_q};

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    addr_d     = addr_q;
    ram_base_d = ram_base_q;
    rd_len_d   = rd_len_q;
    tlp_addr_d = tlp_addr_q;
    rd_en_d    = rd_en_q;
    tx_busy_d  = tx_busy_q;
    done_d     = 1'b0;
    gap_d      = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (i_dma_start) begin
          if (i_dma_len != 16'd0) begin
            remain_d   = {1'b0, i_dma_len};
            addr_d     = i_dma_addr & ~64'h3;
            ram_base_d = '0;
            state_d    = ST_CALC;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_CALC: begin
        rd_len_d   = calc_len;
        tlp_addr_d = addr_q;
        tx_busy_d  = 1'b1;
        state_d    = ST_REQ;
      end
      ST_REQ: begin
        rd_en_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_last_data) begin
          rd_en_d    = 1'b0;
          remain_d   = remain_nx;
          addr_d     = addr_q + {52'd0, rd_len_q, 2'b00};
          ram_base_d = ram_base_q + ADDR_WIDTH'(beats);
          if (remain_nx == 17'd0) begin
            tx_busy_d = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) begin
          state_d = ST_CALC;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      remain_q   <= '0;
      addr_q     <= '0;
      ram_base_q <= '0;
      rd_len_q   <= '0;
      tlp_addr_q <= '0;
      rd_en_q    <= 1'b0;
      tx_busy_q  <= 1'b0;
      done_q     <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      addr_q     <= addr_d;
      ram_base_q <= ram_base_d;
      rd_len_q   <= rd_len_d;
      tlp_addr_q <= tlp_addr_d;
      rd_en_q    <= rd_en_d;
      tx_busy_q  <= tx_busy_d;
      done_q     <= done_d;
      gap_q      <= gap_d;
    end
  end

  assign o_rd_en       = rd_en_q;
  assign o_rd_length   = rd_len_q;
  assign o_mwr_tx_busy = tx_busy_q;
  assign o_tlp_addr    = tlp_addr_q;
  assign o_ram_base    = ram_base_q;
  assign o_dma_done    = done_q;
  assign o_busy        = (state_q != ST_IDLE);

`ifdef IPSL_PCIE_DMA_MWR_PERF_CNT_EN
  logic [15:0] tlp_cnt_q,   tlp_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] wait_cyc_q,  wait_cyc_d;

  // Stall = WAIT cycles beyond the minimum one-beat-per-cycle drain time.
  always_comb begin
    tlp_cnt_d   = tlp_cnt_q;
    stall_cnt_d = stall_cnt_q;
    wait_cyc_d  = wait_cyc_q;
    if (state_q == ST_IDLE && i_dma_start && i_dma_len != 16'd0) begin
      tlp_cnt_d = 16'd0;
    end
    if (state_q == ST_CALC) begin
      tlp_cnt_d  = tlp_cnt_q + 16'd1;
      wait_cyc_d = 16'd0;
    end
    if (state_q == ST_WAIT) begin
      if (wait_cyc_q >= {7'd0, beats} && stall_cnt_q != 32'hFFFF_FFFF) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (wait_cyc_q != 16'hFFFF) begin
        wait_cyc_d = wait_cyc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlp_cnt_q   <= '0;
      stall_cnt_q <= '0;
      wait_cyc_q  <= '0;
    end else begin
      tlp_cnt_q   <= tlp_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cyc_q  <= wait_cyc_d;
    end
  end

  assign o_tlp_cnt   = tlp_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ipsl_pcie_dma_mwr_tlp_sched.sv
// Directed bench for the MWR TLP scheduler with a simple read-controller
// responder and a TLP monitor.
module tb_ipsl_pcie_dma_mwr_tlp_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_dma_start = 1'b0;
  logic [15:0] i_dma_len = '0;
  logic [63:0] i_dma_addr = '0;
  logic [2:0]  i_max_payload = '0;
  logic        i_last_data = 1'b0;
  logic        o_rd_en;
  logic [9:0]  o_rd_length;
  logic        o_mwr_tx_busy;
  logic [63:0] o_tlp_addr;
  logic [8:0]  o_ram_base;
  logic        o_dma_done;
  logic        o_busy;
`ifdef IPSL_PCIE_DMA_MWR_PERF_CNT_EN
  logic [15:0] o_tlp_cnt;
  logic [31:0] o_stall_cnt;
  logic [31:0] stall0;
`endif

  int checks = 0;
  int errs   = 0;
  int hold_cyc = 0;
  int done_cnt = 0;
  logic [63:0] len_q[$];
  logic [63:0] addr_q[$];
  logic [63:0] base_q[$];

  ipsl_pcie_dma_mwr_tlp_sched #(.ADDR_WIDTH(9), .GAP_CYCLES(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_dma_start   (i_dma_start),
    .i_dma_len     (i_dma_len),
    .i_dma_addr    (i_dma_addr),
    .i_max_payload (i_max_payload),
    .i_last_data   (i_last_data),
    .o_rd_en       (o_rd_en),
    .o_rd_length   (o_rd_length),
    .o_mwr_tx_busy (o_mwr_tx_busy),
    .o_tlp_addr    (o_tlp_addr),
    .o_ram_base    (o_ram_base),
    .o_dma_done    (o_dma_done),
`ifdef IPSL_PCIE_DMA_MWR_PERF_CNT_EN
    .o_busy        (o_busy),
    .o_tlp_cnt     (o_tlp_cnt),
    .o_stall_cnt   (o_stall_cnt)
`else
    .o_busy        (o_busy)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_tlp(input string tag, input int idx, input logic [63:0] len,
                         input logic [63:0] addr, input logic [63:0] base);
    chk({tag, "_len"},  len_q[idx],  len);
    chk({tag, "_addr"}, addr_q[idx], addr);
    chk({tag, "_base"}, base_q[idx], base);
  endtask

  task automatic clear_mon();
    len_q.delete();
    addr_q.delete();
    base_q.delete();
    done_cnt = 0;
  endtask

  task automatic start_xfer(input logic [15:0] len, input logic [63:0] addr, input logic [2:0] mps);
    @(negedge clk);
    i_dma_len     = len;
    i_dma_addr    = addr;
    i_max_payload = mps;
    i_dma_start   = 1'b1;
    @(negedge clk);
    i_dma_start   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while ((o_busy || o_dma_done) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle"}, {63'd0, o_busy}, 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Read-controller model: ends each TLP after hold_cyc extra WAIT cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        i_last_data = 1'b0;
        wcnt = 0;
      end else if (i_last_data) begin
        i_last_data = 1'b0;
        wcnt = 0;
      end else if (o_rd_en) begin
        if (wcnt >= hold_cyc) i_last_data = 1'b1;
        else wcnt++;
      end
    end
  end

  initial begin
    logic rd_prev;
    rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_rd_en && !rd_prev) begin
        len_q.push_back({54'd0, o_rd_length});
        addr_q.push_back(o_tlp_addr);
        base_q.push_back({55'd0, o_ram_base});
      end
      if (o_dma_done) done_cnt++;
      rd_prev = o_rd_en;
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_rd_en",   {63'd0, o_rd_en}, 64'd0);
    chk("rst_rd_len",  {54'd0, o_rd_length}, 64'd0);
    chk("rst_txbusy",  {63'd0, o_mwr_tx_busy}, 64'd0);
    chk("rst_addr",    o_tlp_addr, 64'd0);
    chk("rst_base",    {55'd0, o_ram_base}, 64'd0);
    chk("rst_done",    {63'd0, o_dma_done}, 64'd0);
    chk("rst_busy",    {63'd0, o_busy}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 100 DW from 0x1000 at 128 B MPS, with first-request latency
    clear_mon();
    start_xfer(16'd100, 64'h1000, 3'd0);
    chk("t1_busy_c1",  {63'd0, o_busy}, 64'd1);
    chk("t1_rden_c1",  {63'd0, o_rd_en}, 64'd0);
    @(negedge clk);
    chk("t1_rden_c2",  {63'd0, o_rd_en}, 64'd0);
    chk("t1_len_c2",   {54'd0, o_rd_length}, 64'd32);
    chk("t1_txbusy",   {63'd0, o_mwr_tx_busy}, 64'd1);
    @(negedge clk);
    chk("t1_rden_c3",  {63'd0, o_rd_en}, 64'd1);
    wait_idle("t1", 300);
    chk("t1_ntlp", 64'(len_q.size()), 64'd4);
    chk_tlp("t1_0", 0, 32, 64'h1000, 0);
    chk_tlp("t1_1", 1, 32, 64'h1080, 8);
    chk_tlp("t1_2", 2, 32, 64'h1100, 16);
    chk_tlp("t1_3", 3, 4,  64'h1180, 24);
    chk("t1_done", 64'(done_cnt), 64'd1);
    chk("t1_txbusy_end", {63'd0, o_mwr_tx_busy}, 64'd0);

    // 4 KB split: 64 DW from 0x0FF0 at 512 B MPS
    clear_mon();
    start_xfer(16'd64, 64'h0FF0, 3'd2);
    wait_idle("t2", 300);
    chk("t2_ntlp", 64'(len_q.size()), 64'd2);
    chk_tlp("t2_0", 0, 4,  64'h0FF0, 0);
    chk_tlp("t2_1", 1, 60, 64'h1000, 1);
    chk("t2_done", 64'(done_cnt), 64'd1);

    // zero-length start
    clear_mon();
    start_xfer(16'd0, 64'h2000, 3'd0);
    chk("t3_done_c1", {63'd0, o_dma_done}, 64'd1);
    chk("t3_busy_c1", {63'd0, o_busy}, 64'd0);
    @(negedge clk);
    chk("t3_done_c2", {63'd0, o_dma_done}, 64'd0);
    repeat (5) @(negedge clk);
    chk("t3_busy", {63'd0, o_busy}, 64'd0);
    chk("t3_ntlp", 64'(len_q.size()), 64'd0);
    chk("t3_ndone", 64'(done_cnt), 64'd1);

    // second start during WAIT is ignored
    clear_mon();
    hold_cyc = 10;
    start_xfer(16'd96, 64'h0, 3'd0);
    repeat (4) @(negedge clk);
    chk("t4_in_wait", {63'd0, o_rd_en}, 64'd1);
    start_xfer(16'd8, 64'h5000, 3'd0);
    wait_idle("t4", 400);
    chk("t4_ntlp", 64'(len_q.size()), 64'd3);
    chk_tlp("t4_2", 2, 32, 64'h100, 16);
    chk("t4_done", 64'(done_cnt), 64'd1);
    hold_cyc = 0;

    // boundary-aligned start with 256 B MPS
    clear_mon();
    start_xfer(16'd200, 64'h3000, 3'd1);
    wait_idle("t5", 400);
    chk("t5_ntlp", 64'(len_q.size()), 64'd4);
    chk_tlp("t5_0", 0, 64, 64'h3000, 0);
    chk_tlp("t5_3", 3, 8,  64'h3300, 48);

    // reserved MPS encoding decodes to 512 B
    clear_mon();
    start_xfer(16'd300, 64'h4000, 3'd5);
    wait_idle("t6", 400);
    chk("t6_ntlp", 64'(len_q.size()), 64'd3);
    chk_tlp("t6_0", 0, 128, 64'h4000, 0);
    chk_tlp("t6_2", 2, 44,  64'h4400, 64);

    // 2^64 address wrap (also a 4 KB split), unaligned low bits dropped
    clear_mon();
    start_xfer(16'd32, 64'hFFFF_FFFF_FFFF_FFC3, 3'd2);
    wait_idle("t7", 300);
    chk("t7_ntlp", 64'(len_q.size()), 64'd2);
    chk_tlp("t7_0", 0, 16, 64'hFFFF_FFFF_FFFF_FFC0, 0);
    chk_tlp("t7_1", 1, 16, 64'h0, 4);

    // async reset during WAIT of the second TLP
    clear_mon();
    hold_cyc = 10;
    start_xfer(16'd100, 64'h1000, 3'd0);
    n = 0;
    while (len_q.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t8_reach_tlp2", 64'(len_q.size()), 64'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_rd_en",  {63'd0, o_rd_en}, 64'd0);
    chk("t8_txbusy", {63'd0, o_mwr_tx_busy}, 64'd0);
    chk("t8_busy",   {63'd0, o_busy}, 64'd0);
    chk("t8_len",    {54'd0, o_rd_length}, 64'd0);
    chk("t8_addr",   o_tlp_addr, 64'd0);
    chk("t8_base",   {55'd0, o_ram_base}, 64'd0);
    repeat (2) @(negedge clk);
    chk("t8_nodone", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    hold_cyc = 0;
    clear_mon();
    start_xfer(16'd8, 64'h8000, 3'd0);
    wait_idle("t8b", 200);
    chk("t8b_ntlp", 64'(len_q.size()), 64'd1);
    chk_tlp("t8b_0", 0, 8, 64'h8000, 0);
    chk("t8b_done", 64'(done_cnt), 64'd1);

`ifdef IPSL_PCIE_DMA_MWR_PERF_CNT_EN
    // two 32-DW TLPs (8 beats) each held 21 WAIT cycles: 13 stall cycles each
    clear_mon();
    stall0 = o_stall_cnt;
    hold_cyc = 20;
    start_xfer(16'd64, 64'h0, 3'd0);
    wait_idle("t9", 400);
    chk("t9_tlp_cnt", {48'd0, o_tlp_cnt}, 64'd2);
    chk("t9_stall", {32'd0, o_stall_cnt - stall0}, 64'd26);
    hold_cyc = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ipsl_pcie_dma_mwr_tlp_sched.md
Name: ipsl_pcie_dma_mwr_tlp_sched

Overview:
Sequences one host-bound DMA write transfer into a series of MWR TLPs for the MWR read/TLP-generation path.
- Splits each transfer into chunks bounded by max payload size and the 4 KB host-address boundary.
- Per TLP: drives rd_en/rd_length/busy to the read controller, presents the TLP host address and BAR-RAM base, and waits for the last-data beat before issuing the next.
- Sits between the DMA register/command block and the MWR read controller.

Parameters:
ADDR_WIDTH, 9, BAR RAM address width in 128-bit words
GAP_CYCLES, 2, idle cycles between consecutive TLPs (rd_en low), minimum 1

Ports:
clk  in  1  core clock (gen1 62.5 MHz, gen2 125 MHz)
rst_n  in  1  asynchronous active-low reset
i_dma_start  in  1  one-cycle transfer start pulse; ignored unless idle
i_dma_len  in  16  transfer length in DW, 1..65535; 0 treated as no-op
i_dma_addr  in  64  host byte address, DW-aligned (bits[1:0] ignored)
i_max_payload  in  3  PCIe MPS encoding: 0=128B, 1=256B, 2=512B, others=512B
i_last_data  in  1  last beat of current TLP sent by the read controller
o_rd_en  out  1  level request to the read controller, high for one TLP
o_rd_length  out  10  DW length of the current TLP
o_mwr_tx_busy  out  1  high from the first TLP request through the last i_last_data
o_tlp_addr  out  64  host byte address of the current TLP
o_ram_base  out  ADDR_WIDTH  BAR RAM word offset of the current TLP
o_dma_done  out  1  one-cycle pulse after the final TLP completes
o_busy  out  1  scheduler not idle

Behaviour:
Reset: all outputs and registers are 0; state IDLE. Reset mid-transfer aborts immediately with no done pulse.

States:
- IDLE: on i_dma_start with i_dma_len!=0:
  - latch remain=i_dma_len (17-bit), addr=i_dma_addr & ~3, ram_base=0.
  - go to CALC next cycle.
  - i_dma_start with len=0 pulses o_dma_done next cycle and stays IDLE.
- CALC (1 cycle):
  - mps_dw = 32/64/128.
  - bnd_dw = (4096 - addr[11:0]) >> 2, range 1..1024.
  - len = min(remain, mps_dw, bnd_dw); register it to o_rd_length.
  - o_tlp_addr = addr; o_mwr_tx_busy = 1.
  - go to REQ.
- REQ: o_rd_en=1 (a rising edge is seen by the read controller); go to WAIT.
- WAIT:
  - o_rd_en stays 1 until i_last_data.
  - On i_last_data: o_rd_en=0; remain -= len; addr += len*4 (64-bit carry); ram_base += ceil(len/4) (mod 2^ADDR_WIDTH, wraps).
  - If remain reaches 0: go to DONE. Otherwise go to GAP.
- GAP: hold GAP_CYCLES cycles with o_rd_en=0, then go to CALC.
- DONE:
  - o_mwr_tx_busy=0, o_dma_done=1 for one cycle; go to IDLE.
  - o_busy=0 from the cycle after DONE.

Latency: the first o_rd_en rises 3 cycles after the i_dma_start cycle.

Boundary conditions:
- i_last_data outside WAIT is ignored.
- i_dma_start while o_busy is ignored.
- Address exactly on a 4 KB boundary gives bnd_dw=1024, so MPS governs.
- A transfer crossing the 2^64 address wrap wraps silently.
- i_max_payload changes are sampled in CALC only.

Optional Feature:
IPSL_PCIE_DMA_MWR_PERF_CNT_EN. When defined, adds these outputs:
- o_tlp_cnt[15:0]: TLPs issued in the current/last transfer; cleared on accepted start; increments on REQ entry.
- o_stall_cnt[31:0]: WAIT cycles beyond len/4 rounded up (read-controller hold time); saturates at all-ones.
Both are reset to 0. When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
Shared package ipsl_pcie_dma_pkg holds:
- state encoding: IDLE, CALC, REQ, WAIT, GAP, DONE
- MPS decode constants: 32/64/128 DW
- the 4 KB boundary constant

One sub-module, ipsl_pcie_dma_tlp_len_calc, is natural: purely combinational min(remain, mps, bnd) calculation, reusable by the MRD scheduler.

Test Plan:
- Start len=100, addr=0x1000, MPS=0 (128 B) -> TLPs of 32,32,32,4 DW at addrs 0x1000,0x1080,0x1100,0x1180; ram_base 0,8,16,24; one done pulse.
- len=64, addr=0x0FF0, MPS=2 -> TLP1 len=4 at 0x0FF0, TLP2 len=60 at 0x1000 (4 KB split).
- len=0 start -> o_dma_done one cycle later, o_rd_en never asserted, o_busy stays 0.
- Second i_dma_start during WAIT of a 3-TLP transfer -> ignored; exactly 3 TLPs and one done pulse.
- Assert rst_n=0 during WAIT of TLP2 -> all outputs 0 asynchronously; after release, a new start len=8 produces one TLP at ram_base 0.
- i_last_data held off 20 cycles per TLP (PERF_CNT_EN) -> o_stall_cnt accumulates the expected excess; o_tlp_cnt matches the TLP count.
